dmem_access_unit: RTL and testbench
===================================

// Module: dmem_access_unit
// PURPOSE
// Data-memory access controller for the MEM stage. Takes the LW/SW held in the EX/MEM register and
// runs a req/ack handshake with a variable-latency data memory. It stalls the pipeline until the
// access completes, then presents load data to the MEM stage on dmem_data_o, which drives MEM's dmemData.
// Flags misaligned accesses, timeouts and bus errors as faults.
// PARAMETERS
// OPC_LW    7'b0000011  opcode value that denotes a word load
// OPC_SW    7'b0100011  opcode value that denotes a word store
// TIMEOUT   64          max cycles in WAIT without ack before abort (>=1)
// PORTS
// clock         in   1   single clock, rising edge
// reset         in   1   asynchronous, active-LOW reset (0 = in reset)
// valid_i       in   1   EX/MEM register holds a valid instruction
// opcode_i      in   7   opcode of that instruction
// addr_i        in   32  effective address (alu_result)
// store_data_i  in   32  store data for SW
// stall_o       out  1   hold EX/MEM and upstream stages this cycle
// dmem_data_o   out  32  load data to MEM stage
// fault_o       out  1   fault on the access completing this cycle
// fault_cause_o out  2   00 none, 01 misaligned, 10 timeout, 11 bus error
// mem_req_o     out  1   memory request, held until ack
// mem_we_o      out  1   1 = write (SW), 0 = read (LW)
// mem_addr_o    out  32  word address to memory
// mem_wdata_o   out  32  write data
// mem_ack_i     in   1   memory completes request this cycle
// mem_rdata_i   in   32  read data, valid with mem_ack_i on reads
// mem_err_i     in   1   bus error, sampled only with mem_ack_i
// BEHAVIOUR
// - is_mem = valid_i && (opcode_i==OPC_LW || opcode_i==OPC_SW); aligned = addr_i[1:0]==2'b00.
// - States: IDLE, WAIT, DONE.
//   - IDLE & is_mem & aligned: latch addr, wdata and we; set mem_req_o=1; go to WAIT.
//   - IDLE & is_mem & !aligned: no request; go to DONE with cause 01.
//   - IDLE & !is_mem: stay in IDLE; no side effects.
//   - WAIT & mem_ack_i: drop req. On an LW, capture mem_rdata_i into dmem_data_o. Go to DONE; cause = mem_err_i ? 11 : 00.
//   - WAIT & no ack & cnt==TIMEOUT-1: drop req; go to DONE with cause 10; dmem_data_o <= 0 on LW.
//   - DONE: lasts exactly one cycle, then always goes to IDLE. The instruction advances at the end of the DONE cycle, so it is never reissued.
// - stall_o (combinational) = (IDLE & is_mem) | WAIT. It is 0 in DONE and 0 while reset is low.
// - fault_o = DONE & (cause!=00), registered with the state. fault_cause_o is valid in DONE and 00 otherwise.
// - Handshake:
//   - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are registered and stay stable while mem_req_o=1.
//   - mem_ack_i (and mem_err_i) is ignored when mem_req_o=0.
//   - mem_rdata_i is ignored on SW.
// - Latency: minimum 2 stall cycles per access (request cycle + one WAIT cycle with immediate ack). N-cycle ack adds N-1 stalls. Misaligned access costs 1 stall cycle.
// - dmem_data_o changes only on LW completion. It holds its value across SW, non-memory ops and bubbles.
// - WAIT counter is $clog2(TIMEOUT+1) bits wide, cleared on entry to WAIT, saturates at TIMEOUT-1.
// - Reset (async, reset==0):
//   - state=IDLE, counter=0.
//   - All registered outputs are 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, dmem_data_o, fault_o, fault_cause_o.
//   - An in-flight request is abandoned immediately; the memory tolerates a request dropped before ack.
// TESTING
// 1. LW 0x100, ack in first WAIT cycle with rdata 0xCAFEBABE -> stall_o=1 for 2 cycles; mem_we_o=0; DONE shows dmem_data_o=0xCAFEBABE, fault_o=0.
// 2. SW 0x204 with data 0x12345678, ack 3 cycles after req rises -> mem_we_o=1; addr and wdata stable throughout req; stall_o=1 for 4 cycles; dmem_data_o unchanged.
// 3. LW 0x102 -> mem_req_o never rises; stall_o=1 for 1 cycle; DONE has fault_o=1, cause 01.
// 4. TIMEOUT=8, LW with no ack -> req high exactly 8 cycles then drops; DONE has cause 10, dmem_data_o=0. A late ack afterwards is ignored.
// 5. Ack with mem_err_i=1 on SW -> DONE cause 11. Next back-to-back LW issues its request in the cycle after DONE.
// 6. reset driven low mid-WAIT -> mem_req_o=0 and stall_o=0 without waiting for a clock edge. After release, ALU ops and bubbles with stray acks give stall_o=0 and no req; the following LW completes normally.

Source files
------------

// File: rtl/dmem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the memory (slave).
// The request side is registered by the master and held stable while mem_req_o is high.
interface dmem_access_unit_if;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        mem_err_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_ack_i, mem_rdata_i, mem_err_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_ack_i, mem_rdata_i, mem_err_i
   );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access controller. Runs one LW/SW at a time over a
// req/ack bus, stalls the pipeline until the access resolves and reports
// misalignment, timeout and bus-error faults in a single-cycle DONE state.
module dmem_access_unit #(
   parameter logic [6:0] OPC_LW  = 7'b0000011,
   parameter logic [6:0] OPC_SW  = 7'b0100011,
   parameter int         TIMEOUT = 64
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       valid_i,
   input  logic [6:0]                 opcode_i,
   input  logic [31:0]                addr_i,
   input  logic [31:0]                store_data_i,
   output logic                       stall_o,
   output logic [31:0]                dmem_data_o,
   output logic                       fault_o,
   output logic [1:0]                 fault_cause_o,
   dmem_access_unit_if.master         mem
);

   localparam int             CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_ALIGN = 2'b01;
   localparam logic [1:0] CAUSE_TMO   = 2'b10;
   localparam logic [1:0] CAUSE_BUS   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           req_q, req_d;
   logic           we_q, we_d;
   logic [31:0]    addr_q, addr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [31:0]    dmem_q, dmem_d;
   logic           fault_q, fault_d;
   logic [1:0]     cause_q, cause_d;

   logic           is_mem;
   logic           aligned;
   logic           ack_seen;

   assign is_mem   = valid_i && ((opcode_i == OPC_LW) || (opcode_i == OPC_SW));
   assign aligned  = (addr_i[1:0] == 2'b00);
   // Acks only count while a request is actually outstanding.
   assign ack_seen = req_q && mem.mem_ack_i;

   // Next-state and registered-output logic for the access FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      dmem_d  = dmem_q;
      cause_d = CAUSE_NONE;
      fault_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (is_mem) begin
               if (aligned) begin
                  req_d   = 1'b1;
                  we_d    = (opcode_i == OPC_SW);
                  addr_d  = addr_i;
                  wdata_d = store_data_i;
                  cnt_d   = '0;
                  state_d = S_WAIT;
               end else begin
                  cause_d = CAUSE_ALIGN;
                  state_d = S_DONE;
               end
            end
         end
         S_WAIT: begin
            if (ack_seen) begin
               req_d   = 1'b0;
               if (!we_q) begin
                  dmem_d = mem.mem_rdata_i;
               end
               cause_d = mem.mem_err_i ? CAUSE_BUS : CAUSE_NONE;
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               req_d   = 1'b0;
               if (!we_q) begin
                  dmem_d = '0;
               end
               cause_d = CAUSE_TMO;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      fault_d = (cause_d != CAUSE_NONE);
   end

   // State, counter and all registered outputs; reset abandons any request.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         dmem_q  <= '0;
         fault_q <= 1'b0;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         dmem_q  <= dmem_d;
         fault_q <= fault_d;
         cause_q <= cause_d;
      end
   end

   // Stall is combinational and forced low while reset is asserted.
   assign stall_o = reset && (((state_q == S_IDLE) && is_mem) || (state_q == S_WAIT));

   assign dmem_data_o     = dmem_q;
   assign fault_o         = fault_q;
   assign fault_cause_o   = cause_q;
   assign mem.mem_req_o   = req_q;
   assign mem.mem_we_o    = we_q;
   assign mem.mem_addr_o  = addr_q;
   assign mem.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed and random LW/SW/ALU/bubble traffic,
// a latency-programmable memory responder, and a scoreboard monitor.
module tb_dmem_access_unit;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] ALU = 7'b0110011;
   localparam int         TO  = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic        valid_i;
   logic [6:0]  opcode_i;
   logic [31:0] addr_i;
   logic [31:0] store_data_i;
   logic        stall_o;
   logic [31:0] dmem_data_o;
   logic        fault_o;
   logic [1:0]  fault_cause_o;

   dmem_access_unit_if mem_if();

   dmem_access_unit #(.OPC_LW(LW), .OPC_SW(SW), .TIMEOUT(TO)) dut (
      .clock         (clock),
      .reset         (reset),
      .valid_i       (valid_i),
      .opcode_i      (opcode_i),
      .addr_i        (addr_i),
      .store_data_i  (store_data_i),
      .stall_o       (stall_o),
      .dmem_data_o   (dmem_data_o),
      .fault_o       (fault_o),
      .fault_cause_o (fault_cause_o),
      .mem           (mem_if)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          stalls;
      int          reqs;
      bit          fault;
      logic [1:0]  cause;
      logic [31:0] dmem;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_pass = 0;

   // responder configuration and expected bus contents for the current access
   int          cfg_lat;
   bit          cfg_err;
   logic [31:0] cfg_rdata;
   logic [31:0] exp_addr;
   bit          exp_we;
   logic [31:0] exp_wdata;
   logic [31:0] ref_dmem;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Memory model: ack after cfg_lat request cycles; random stray acks when idle.
   initial begin
      int wcnt;
      wcnt = 0;
      mem_if.mem_ack_i   = 1'b0;
      mem_if.mem_err_i   = 1'b0;
      mem_if.mem_rdata_i = '0;
      forever begin
         @(posedge clock);
         #1;
         if (mem_if.mem_req_o) begin
            wcnt++;
            mem_if.mem_ack_i   = (wcnt == cfg_lat);
            mem_if.mem_err_i   = (wcnt == cfg_lat) ? cfg_err : 1'($urandom_range(0, 1));
            mem_if.mem_rdata_i = (wcnt == cfg_lat) ? cfg_rdata : $urandom;
         end else begin
            wcnt = 0;
            mem_if.mem_ack_i   = ($urandom_range(0, 2) == 0);
            mem_if.mem_err_i   = 1'($urandom_range(0, 1));
            mem_if.mem_rdata_i = $urandom;
         end
      end
   end

   // Scoreboard monitor: sampled on the falling edge.
   initial begin
      int          stall_run;
      int          req_run;
      logic [31:0] mon_dmem;
      bit          is_mem_in;
      exp_t        e;
      stall_run = 0;
      req_run   = 0;
      mon_dmem  = '0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            stall_run = 0;
            req_run   = 0;
            mon_dmem  = '0;
         end else begin
            is_mem_in = valid_i && ((opcode_i == LW) || (opcode_i == SW));
            if (mem_if.mem_req_o) begin
               req_run++;
               chk("req_addr", mem_if.mem_addr_o, exp_addr);
               chk("req_we", 32'(mem_if.mem_we_o), 32'(exp_we));
               if (exp_we) chk("req_wdata", mem_if.mem_wdata_o, exp_wdata);
            end
            if (is_mem_in) begin
               if (stall_o) begin
                  stall_run++;
                  chk("fault_while_busy", {29'd0, fault_o, fault_cause_o}, 32'd0);
               end else if (sb.size() == 0) begin
                  chk("unexpected_completion", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("stall_cycles", 32'(stall_run), 32'(e.stalls));
                  chk("req_cycles", 32'(req_run), 32'(e.reqs));
                  chk("req_dropped", 32'(mem_if.mem_req_o), 32'd0);
                  chk("fault", 32'(fault_o), 32'(e.fault));
                  chk("cause", 32'(fault_cause_o), 32'(e.cause));
                  chk("dmem_data", dmem_data_o, e.dmem);
                  mon_dmem  = e.dmem;
                  stall_run = 0;
                  req_run   = 0;
               end
            end else begin
               chk("idle_stall", 32'(stall_o), 32'd0);
               chk("idle_req", 32'(mem_if.mem_req_o), 32'd0);
               chk("idle_fault", {29'd0, fault_o, fault_cause_o}, 32'd0);
               chk("dmem_hold", dmem_data_o, mon_dmem);
            end
         end
      end
   end

   // Present one instruction (called just after a rising edge) and hold it until it advances.
   task automatic issue(input bit v, input logic [6:0] opc, input logic [31:0] a,
                        input logic [31:0] wd, input int l, input bit er, input logic [31:0] rd);
      bit   mem_op;
      exp_t e;
      int   bound;
      cfg_lat = l; cfg_err = er; cfg_rdata = rd;
      exp_addr = a; exp_we = (opc == SW); exp_wdata = wd;
      valid_i = v; opcode_i = opc; addr_i = a; store_data_i = wd;
      mem_op = v && ((opc == LW) || (opc == SW));
      if (mem_op) begin
         if (a[1:0] != 2'b00) begin
            e.stalls = 1; e.reqs = 0; e.fault = 1'b1; e.cause = 2'b01;
         end else if (l <= TO) begin
            e.stalls = 1 + l; e.reqs = l; e.fault = er; e.cause = er ? 2'b11 : 2'b00;
            if (opc == LW) ref_dmem = rd;
         end else begin
            e.stalls = 1 + TO; e.reqs = TO; e.fault = 1'b1; e.cause = 2'b10;
            if (opc == LW) ref_dmem = '0;
         end
         e.dmem = ref_dmem;
         sb.push_back(e);
         bound = 0;
         do begin
            @(negedge clock);
            bound++;
         end while (stall_o && bound < 40);
         if (bound >= 40) begin
            chk("completion_timeout", 32'(stall_o), 32'd0);
            $display("%0d/%0d checks passed", n_pass, n_chk);
            $finish;
         end
      end else begin
         @(negedge clock);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic random_ops(input int n);
      for (int i = 0; i < n; i++) begin
         int          k;
         logic [31:0] a;
         k = $urandom_range(0, 9);
         a = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
         if (k < 2)      issue(1'b0, ($urandom_range(0, 1) != 0) ? LW : ALU, a, $urandom, 1, 1'b0, 0);
         else if (k < 4) issue(1'b1, ALU, a, $urandom, 1, 1'b0, 0);
         else            issue(1'b1, (k < 7) ? LW : SW, a, $urandom, $urandom_range(1, 10),
                               ($urandom_range(0, 5) == 0), $urandom);
      end
   endtask

   initial begin
      ref_dmem = '0;
      cfg_lat = 1; cfg_err = 1'b0; cfg_rdata = '0;
      exp_addr = '0; exp_we = 1'b0; exp_wdata = '0;
      reset = 1'b0;
      valid_i = 1'b1; opcode_i = LW; addr_i = 32'h100; store_data_i = '0;
      #12;
      chk("rst_req", 32'(mem_if.mem_req_o), 32'd0);
      chk("rst_we", 32'(mem_if.mem_we_o), 32'd0);
      chk("rst_addr", mem_if.mem_addr_o, 32'd0);
      chk("rst_wdata", mem_if.mem_wdata_o, 32'd0);
      chk("rst_dmem", dmem_data_o, 32'd0);
      chk("rst_fault", {29'd0, fault_o, fault_cause_o}, 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      valid_i = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;

      issue(1'b1, LW, 32'h100, 32'h0, 1, 1'b0, 32'hCAFEBABE);
      issue(1'b1, SW, 32'h204, 32'h12345678, 3, 1'b0, 32'hDEAD0000);
      issue(1'b1, LW, 32'h102, 32'h0, 1, 1'b0, 32'h11111111);
      issue(1'b1, LW, 32'h300, 32'h0, 20, 1'b0, 32'h22222222);
      issue(1'b1, SW, 32'h400, 32'hA5A5A5A5, 2, 1'b1, 32'h0);
      issue(1'b1, LW, 32'h404, 32'h0, 1, 1'b0, 32'h0BADF00D);
      random_ops(150);

      // reset in the middle of a pending load
      cfg_lat = 30; exp_addr = 32'h40; exp_we = 1'b0;
      valid_i = 1'b1; opcode_i = LW; addr_i = 32'h40;
      repeat (3) @(posedge clock);
      #3 reset = 1'b0;
      #1;
      chk("midrst_req", 32'(mem_if.mem_req_o), 32'd0);
      chk("midrst_stall", 32'(stall_o), 32'd0);
      chk("midrst_dmem", dmem_data_o, 32'd0);
      valid_i = 1'b0;
      ref_dmem = '0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;

      for (int i = 0; i < 6; i++) issue(1'b1, ALU, $urandom, 0, 1, 1'b0, 0);
      for (int i = 0; i < 6; i++) issue(1'b0, LW, $urandom & 32'hFFFF_FFFC, 0, 1, 1'b0, 0);
      issue(1'b1, LW, 32'h80, 32'h0, 2, 1'b0, 32'h5EED5EED);
      random_ops(100);

      valid_i = 1'b0;
      repeat (3) @(posedge clock);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
